shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 clear  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level request to execute instructions; sampled in IDLE and T5.
REQ-005 ir  input  32  IR contents from datapath: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-006 PCout, IncPC, MARin, Zin, Zlo_out, PCin, Read, MDRin, MDRout, IRin, Yin  output  1 each  datapath control strobes.
REQ-007 Rout  output  16  one-hot general-register bus-drive select (bit n = Rnout).
REQ-008 Rin  output  16  one-hot general-register load select (bit n = Rnin).
REQ-009 opcode  output  5  ALU operation select.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse in T5 of a legal instruction.
REQ-012 illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-013 instr_count  output  CNT_W  number of retired legal instructions.

Function
REQ-014 States: IDLE, T0, T1, T2, T3, T4, T5; outputs are decoded from the state register and ir only.
REQ-015 IDLE: all strobes, Rout, Rin low; opcode = 0; IDLE->T0 when run=1, else stay.
REQ-016 T0: PCout, IncPC, MARin, Zin high; ->T1.
REQ-017 T1: Zlo_out, PCin, Read, MDRin high; ->T2.
REQ-018 T2: MDRout, IRin high; ->T3; ir is valid from T3 onward.
REQ-019 T3: decode ir[31:27]; legal set: 00101 shr, 00110 shra, 00111 shl (plus REQ-032); if legal, Rout[Rb] and Yin high, ->T4; if illegal, illegal=1, no strobes, ->IDLE.
REQ-020 T4: Rout[Rc], Zin high; opcode = ir[31:27]; ->T5.
REQ-021 T5: Zlo_out, Rin[Ra] high; done=1; instr_count increments; ->T0 if run=1, else ->IDLE.
REQ-022 opcode output is ir[31:27] in T4 only, 0 in all other states.
REQ-023 Latency: run high in IDLE at edge k -> T0 at k+1 -> done in T5 at k+6; back-to-back instructions every 6 cycles.
REQ-024 At most one bit of Rout and one bit of Rin set in any cycle; Ra=Rb=Rc permitted and decoded normally.
REQ-025 run deasserted mid-instruction has no effect; the instruction completes through T5.
REQ-026 instr_count wraps from 2^CNT_W-1 to 0 without side effect.
REQ-027 Illegal opcode performs no register write and does not change instr_count.

Reset
REQ-028 clear=0 forces IDLE immediately, regardless of current state, with all outputs 0 and instr_count = 0.
REQ-029 Reset mid-instruction aborts it: no Rin pulse, no done, no partial count.
REQ-030 First T0 after clear release requires run=1 sampled at a rising edge with clear=1.

Configuration
REQ-031 Macro SHIFT_SEQ_ROTATE_EN selects rotate support.
REQ-032 Defined: opcodes 01000 ror and 01001 rol are legal and follow T3-T5 identically; undefined: they are illegal per REQ-019.

Verification
REQ-033 Reset, run=1, ir=32'h28918000 -> T0..T5 strobes per REQ-016..021, Rout=16'h0004 in T3, 16'h0008 in T4, opcode=5'b00101 in T4, Rin=16'h0002 and done in T5, instr_count=1.
REQ-034 run held high, ir 32'h30918000 then 32'h38918000 -> opcode 00110 then 00111 in successive T4 cycles 6 cycles apart, instr_count=2.
REQ-035 ir=32'hF8918000 -> illegal pulse in T3, Rin never nonzero, next state IDLE, instr_count unchanged.
REQ-036 clear=0 during T4 -> outputs 0 same cycle, state IDLE, no done; after release with run=0 stays IDLE.
REQ-037 ir=32'h40918000 -> illegal without SHIFT_SEQ_ROTATE_EN; with it, opcode=01000 in T4 and done in T5.
REQ-038 CNT_W=2, 5 legal instructions -> instr_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/shift_sequencer.sv
// Shift-instruction control sequencer: fetch (T0-T2), decode (T3), execute (T4-T5).
// Define SHIFT_SEQ_ROTATE_EN to also accept the ror/rol opcodes.
module shift_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             IncPC,
  output logic             MARin,
  output logic             Zin,
  output logic             Zlo_out,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic [4:0]       opcode,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6
  } state_t;

  state_t state;
  logic   legal;
  logic   unused_ir;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      5'b00101, 5'b00110, 5'b00111: is_legal = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
      5'b01000, 5'b01001:           is_legal = 1'b1;
`else
`endif
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] reg_sel(input logic [3:0] idx);
    reg_sel = 16'h0001 << idx;
  endfunction

  assign legal     = is_legal(ir[31:27]);
  assign unused_ir = ^ir[14:0];

  // State register and retired-instruction counter
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      instr_count <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE:    state <= run ? T0 : IDLE;
        T0:      state <= T1;
        T1:      state <= T2;
        T2:      state <= T3;
        T3:      state <= legal ? T4 : IDLE;
        T4:      state <= T5;
        T5: begin
          instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
          state       <= run ? T0 : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Control strobes decoded from the state register and the IR fields
  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    Zlo_out = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Rout    = 16'h0000;
    Rin     = 16'h0000;
    opcode  = 5'b00000;
    done    = 1'b0;
    illegal = 1'b0;
    case (state)
      T0: begin
        PCout = 1'b1;
        IncPC = 1'b1;
        MARin = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlo_out = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (legal) begin
          Rout = reg_sel(ir[22:19]);
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      T4: begin
        Rout   = reg_sel(ir[18:15]);
        Zin    = 1'b1;
        opcode = ir[31:27];
      end
      T5: begin
        Zlo_out = 1'b1;
        Rin     = reg_sel(ir[26:23]);
        done    = 1'b1;
      end
      default: begin
        PCout = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a feeder supplies IR on each fetch and queues the
// expected retirement; a monitor compares each done/illegal pulse against the queue.
module tb_shift_sequencer;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          clear;
  logic          run;
  logic [31:0]   ir;
  logic          PCout, IncPC, MARin, Zin, Zlo_out, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic [15:0]   Rout, Rin;
  logic [4:0]    opcode;
  logic          busy, done, illegal;
  logic [CW-1:0] instr_count;
  logic [10:0]   strobes;

  shift_sequencer #(.CNT_W(CW)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Rout(Rout), .Rin(Rin), .opcode(opcode), .busy(busy), .done(done),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  assign strobes = {PCout, IncPC, MARin, Zin, Zlo_out, PCin, Read, MDRin, MDRout, IRin, Yin};

  typedef struct {
    logic          legal;
    logic [15:0]   ra, rb, rc;
    logic [4:0]    op;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  logic [31:0]   ir_q[$];
  int            done_cyc_q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            cnt_model = 0;
  logic          cnt_pend = 1'b0;
  logic          idle_pend = 1'b0;
  logic [CW-1:0] cnt_exp;
  logic [15:0]   cap_rb, cap_rc;
  logic [4:0]    cap_op;
  exp_t          fe, me;
  logic [31:0]   nir;

  function automatic logic model_legal(input logic [4:0] op);
    logic ok;
    ok = (op >= 5'd5) && (op <= 5'd7);
`ifdef SHIFT_SEQ_ROTATE_EN
    ok = ok || (op == 5'd8) || (op == 5'd9);
`endif
    return ok;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Feeder: the datapath answers each fetch with the next queued IR; expectation is queued
  always @(negedge clock) begin
    if (clear && IRin) begin
      if (ir_q.size() == 0) begin
        check("fetch_without_stimulus", 64'd1, 64'd0);
      end else begin
        nir      = ir_q.pop_front();
        ir       = nir;
        fe.legal = model_legal(nir[31:27]);
        fe.op    = nir[31:27];
        fe.ra    = 16'h0001 << nir[26:23];
        fe.rb    = 16'h0001 << nir[22:19];
        fe.rc    = 16'h0001 << nir[18:15];
        if (fe.legal) cnt_model = (cnt_model + 1) % (1 << CW);
        fe.cnt   = cnt_model[CW-1:0];
        exp_q.push_back(fe);
      end
    end
  end

  // Monitor: capture operand selects, then score each retirement against the queue
  always @(negedge clock) begin
    if (clear) begin
      if (cnt_pend) begin
        check("instr_count", instr_count, cnt_exp);
        cnt_pend = 1'b0;
      end
      if (idle_pend) begin
        check("idle_after_illegal", busy, 1'b0);
        idle_pend = 1'b0;
      end
      check("rin_only_with_done", (Rin != 16'h0000), done);
      check("rout_onehot0", ($countones(Rout) <= 1), 1'b1);
      if (IRin) begin
        cap_rb = 16'h0000;
        cap_rc = 16'h0000;
        cap_op = 5'd0;
      end
      if (Yin) cap_rb = Rout;
      if (Zin && !PCout) begin
        cap_rc = Rout;
        cap_op = opcode;
      end
      if (done || illegal) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 64'd1, 64'd0);
        end else begin
          me = exp_q.pop_front();
          check("done_flag", done, me.legal);
          check("illegal_flag", illegal, !me.legal);
          if (me.legal) begin
            check("rout_rb", cap_rb, me.rb);
            check("rout_rc", cap_rc, me.rc);
            check("opcode_t4", cap_op, me.op);
            check("rin_ra", Rin, me.ra);
            cnt_exp  = me.cnt;
            cnt_pend = 1'b1;
            done_cyc_q.push_back(cyc);
          end else begin
            idle_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_queue(input bit drops);
    int n;
    n = 0;
    run = 1'b1;
    while (ir_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      #2;
      n++;
      if (ir_q.size() != 0 && drops) run = ($urandom_range(0, 9) != 0);
    end
    run = 1'b0;
    if (n >= 3000) check("run_queue_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && !cnt_pend && !idle_pend && !busy) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 64'd1, 64'd0);
  endtask

  logic [10:0] t_str [6];
  logic [15:0] t_rout[6];
  logic [15:0] t_rin [6];
  logic [4:0]  t_op  [6];
  logic [31:0] rnd;
  logic [4:0]  rop;
  bit          found;

  initial begin
    t_str = '{11'b11110000000, 11'b00001111000, 11'b00000000110,
              11'b00000000001, 11'b00010000000, 11'b00001000000};
    t_rout = '{16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h0008, 16'h0000};
    t_rin  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002};
    t_op   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00101, 5'd0};

    clear = 1'b0;
    run   = 1'b0;
    ir    = 32'h0000_0000;
    repeat (2) @(negedge clock);
    check("reset_outputs", {strobes, busy, done, illegal, Rout, Rin, opcode, instr_count}, 64'd0);
    clear = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("idle_hold_run0", busy, 1'b0);
    end

    // Directed shr: cycle-by-cycle strobes, latency 6, run dropped mid-instruction
    ir_q.push_back(32'h2891_8000);
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 0) run = 1'b0;
      check($sformatf("t%0d_outputs", i), {strobes, busy, done, Rout, Rin, opcode},
            {t_str[i], 1'b1, (i == 5), t_rout[i], t_rin[i], t_op[i]});
    end
    wait_drain();

    // Back-to-back shra/shl: retirements exactly 6 cycles apart
    done_cyc_q.delete();
    ir_q.push_back(32'h3091_8000);
    ir_q.push_back(32'h3891_8000);
    run_queue(1'b0);
    wait_drain();
    check("b2b_retire_count", done_cyc_q.size(), 2);
    if (done_cyc_q.size() == 2) check("b2b_spacing", done_cyc_q[1] - done_cyc_q[0], 6);

    // Illegal opcode, rotate opcode, then a legal one
    ir_q.push_back(32'hF891_8000);
    ir_q.push_back(32'h4091_8000);
    ir_q.push_back(32'h2891_8000);
    run_queue(1'b0);
    wait_drain();

    // Reset during T4 aborts the instruction
    ir_q.push_back(32'h3091_8000);
    run_queue(1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (Zin && !PCout) found = 1'b1;
    end
    check("reach_t4", found, 1'b1);
    #1 clear = 1'b0;
    #1 check("reset_mid_t4", {strobes, busy, done, illegal, Rout, Rin, opcode, instr_count}, 64'd0);
    exp_q.delete();
    done_cyc_q.delete();
    cnt_pend  = 1'b0;
    idle_pend = 1'b0;
    cnt_model = 0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("idle_after_reset", busy, 1'b0);
    end
    check("no_done_after_abort", done_cyc_q.size(), 0);

    // Random mix with random run gaps; counter wraps every four legal retirements
    for (int k = 0; k < 40; k++) begin
      rnd = $urandom();
      case ($urandom_range(0, 7))
        0: rop = 5'b00101;
        1: rop = 5'b00110;
        2: rop = 5'b00111;
        3: rop = 5'b01000;
        4: rop = 5'b01001;
        default: rop = rnd[4:0];
      endcase
      rnd[31:27] = rop;
      ir_q.push_back(rnd);
    end
    run_queue(1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
